// File: rtl/iir_wb_master_if.sv
// Wishbone classic bundle between the IIR block master and the slave filter register block.
interface iir_wb_master_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i, wbm_err_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i, wbm_err_i
    );
endinterface

// File: rtl/iir_wb_master.sv
// Wishbone master that streams a block of samples into the slave IIR filter,
// kicks a run, polls data_valid and copies the filtered block into a local result buffer.
//
// state           | meaning
// IDLE            | waiting for start_i, host owns the input buffer
// LD_ADDR..LD_W0  | write index, sample, dataW=1, dataW=0 for sample i
// NXT1/NXT0       | pulse the slave "next" bit to start a filter run
// POLL            | read data_valid until set or poll budget spent
// RD_ADDR/RD_DATA | select result i, read it back into the result buffer
// DONE / ERR      | one-cycle exit states back to IDLE
module iir_wb_master #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          N_SAMPLES  = 32,
    parameter int          POLL_LIMIT = 1024
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    iir_wb_master_if.master wbm,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    input  logic            in_we_i,
    input  logic [4:0]      in_addr_i,
    input  logic [31:0]     in_data_i,
    input  logic [4:0]      out_addr_i,
    output logic [31:0]     out_data_o
);
    localparam int              PW        = $clog2(POLL_LIMIT + 1);
    localparam logic [4:0]      LAST_IDX  = 5'(N_SAMPLES - 1);
    localparam logic [PW-1:0]   LAST_POLL = PW'(POLL_LIMIT - 1);
    localparam logic [31:0]     OFS_NEXT  = 32'h00;
    localparam logic [31:0]     OFS_DATAW = 32'h04;
    localparam logic [31:0]     OFS_WADDR = 32'h08;
    localparam logic [31:0]     OFS_WIN   = 32'h0C;
    localparam logic [31:0]     OFS_RADDR = 32'h10;
    localparam logic [31:0]     OFS_VALID = 32'h10;
    localparam logic [31:0]     OFS_ROUT  = 32'h1C;

    typedef enum logic [3:0] {
        IDLE, LD_ADDR, LD_DATA, LD_W1, LD_W0, NXT1, NXT0,
        POLL, RD_ADDR, RD_DATA, DONE, ERR
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    idx_q, idx_d;
    logic [PW-1:0] poll_q, poll_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;

    logic          bus_state;
    logic          req_we;
    logic [31:0]   req_ofs;
    logic [31:0]   req_dat;
    logic          xfer_end;
    logic          xfer_ok;
    logic          res_we;

    logic [31:0]   in_buf  [32];
    logic [31:0]   res_buf [32];

    always_comb begin
        bus_state = 1'b1;
        req_we    = 1'b1;
        req_ofs   = 32'h0;
        req_dat   = 32'h0;
        case (state_q)
            LD_ADDR: begin req_ofs = OFS_WADDR; req_dat = {27'b0, idx_q}; end
            LD_DATA: begin req_ofs = OFS_WIN;   req_dat = in_buf[idx_q];  end
            LD_W1:   begin req_ofs = OFS_DATAW; req_dat = 32'h1;          end
            LD_W0:   begin req_ofs = OFS_DATAW; req_dat = 32'h0;          end
            NXT1:    begin req_ofs = OFS_NEXT;  req_dat = 32'h1;          end
            NXT0:    begin req_ofs = OFS_NEXT;  req_dat = 32'h0;          end
            POLL:    begin req_ofs = OFS_VALID; req_we  = 1'b0;           end
            RD_ADDR: begin req_ofs = OFS_RADDR; req_dat = {27'b0, idx_q}; end
            RD_DATA: begin req_ofs = OFS_ROUT;  req_we  = 1'b0;           end
            default: begin bus_state = 1'b0;    req_we  = 1'b0;           end
        endcase
    end

    // err wins over ack when both are sampled together
    assign xfer_end = cyc_q & (wbm.wbm_ack_i | wbm.wbm_err_i);
    assign xfer_ok  = xfer_end & ~wbm.wbm_err_i;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        poll_d  = poll_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        res_we  = 1'b0;

        if (bus_state && !cyc_q) begin
            cyc_d = 1'b1;
            we_d  = req_we;
            adr_d = BASE_ADDR + req_ofs;
            dat_d = req_dat;
        end
        if (xfer_end) begin
            cyc_d = 1'b0;
            we_d  = 1'b0;
            adr_d = 32'h0;
            dat_d = 32'h0;
        end

        case (state_q)
            IDLE: if (start_i) begin
                state_d = LD_ADDR;
                idx_d   = 5'd0;
                poll_d  = '0;
                err_d   = 1'b0;
            end
            LD_ADDR: if (xfer_ok) state_d = LD_DATA;
            LD_DATA: if (xfer_ok) state_d = LD_W1;
            LD_W1:   if (xfer_ok) state_d = LD_W0;
            LD_W0: if (xfer_ok) begin
                if (idx_q == LAST_IDX) begin
                    state_d = NXT1;
                    idx_d   = 5'd0;
                end else begin
                    state_d = LD_ADDR;
                    idx_d   = idx_q + 5'd1;
                end
            end
            NXT1: if (xfer_ok) state_d = NXT0;
            NXT0: if (xfer_ok) begin
                state_d = POLL;
                poll_d  = '0;
            end
            POLL: if (xfer_ok) begin
                if (wbm.wbm_dat_i[0]) begin
                    state_d = RD_ADDR;
                    idx_d   = 5'd0;
                end else if (poll_q == LAST_POLL) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    poll_d  = poll_q + 1'b1;
                end
            end
            RD_ADDR: if (xfer_ok) state_d = RD_DATA;
            RD_DATA: if (xfer_ok) begin
                res_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = RD_ADDR;
                    idx_d   = idx_q + 5'd1;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (xfer_end && wbm.wbm_err_i) begin
            state_d = ERR;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            poll_q  <= '0;
            err_q   <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 32'h0;
            dat_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            poll_q  <= poll_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    // Buffers are deliberately not reset so a reset preserves their contents
    always_ff @(posedge wb_clk_i) begin
        if (in_we_i && !busy_o) in_buf[in_addr_i] <= in_data_i;
        if (res_we)             res_buf[idx_q]    <= wbm.wbm_dat_i;
    end

    assign busy_o        = (state_q != IDLE) && (state_q != DONE) && (state_q != ERR);
    assign done_o        = (state_q == DONE);
    assign error_o       = err_q;
    assign out_data_o    = res_buf[out_addr_i];

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign wbm.wbm_sel_o = 4'hF;
endmodule

// File: tb/tb_iir_wb_master.sv
// Bench for iir_wb_master: a behavioural filter slave checks every bus transaction
// against a queue of expected transactions and the result buffer against a reference filter.
`timescale 1ns/1ps
module tb_iir_wb_master;
    localparam logic [31:0] BASE = 32'h0000_4000;
    localparam int          N    = 32;
    localparam int          PL   = 8;
    localparam int          ALL  = 100000;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_we = 1'b0;
    logic [4:0]  in_addr = 5'd0;
    logic [31:0] in_data = 32'h0;
    logic [4:0]  out_addr = 5'd0;
    logic [31:0] out_data;
    logic        busy, done, error;

    iir_wb_master_if bus ();

    iir_wb_master #(.BASE_ADDR(BASE), .N_SAMPLES(N), .POLL_LIMIT(PL)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbm        (bus),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .in_we_i    (in_we),
        .in_addr_i  (in_addr),
        .in_data_i  (in_data),
        .out_addr_i (out_addr),
        .out_data_o (out_data)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    txn_t exp_q[$];

    int   wait_states = 0, valid_delay = 0, err_on = 0;
    bit   never_valid = 1'b0, chk_len = 1'b0;
    int   txn_cnt = 0, cyc_len = 0, stable_cnt = 0, poll_cnt = 0;
    logic [31:0] first_adr = 32'h0;
    logic [31:0] xmem [N];
    logic [31:0] ymem [N];
    logic [4:0]  waddr = 5'd0, raddr = 5'd0;
    logic [31:0] win = 32'h0;
    bit   dataw_prev = 1'b0, next_prev = 1'b0, run_done = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] iir_ref(input int k);
        logic [31:0] acc;
        acc = 32'h0;
        for (int j = 0; j <= k; j++) acc = 32'(j + 1) + (acc >> 1);
        return acc;
    endfunction

    task automatic run_filter();
        logic [31:0] y;
        y = 32'h0;
        for (int k = 0; k < N; k++) begin
            y = xmem[k] + (y >> 1);
            ymem[k] = y;
        end
        run_done = 1'b1;
        poll_cnt = 0;
    endtask

    task automatic slave_respond();
        txn_t        e;
        logic [31:0] ofs;
        txn_cnt++;
        if (chk_len) begin
            chk("cyc_len", 32'(cyc_len), 32'(wait_states + 1));
            chk("adr_stable", 32'(stable_cnt), 32'(cyc_len));
        end
        chk("sel", 32'(bus.wbm_sel_o), 32'hF);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else begin
            e.we = 1'b0; e.adr = 32'hDEAD_BEEF; e.dat = 32'h0;
        end
        chk("txn_adr", bus.wbm_adr_o, e.adr);
        chk("txn_we", 32'(bus.wbm_we_o), 32'(e.we));
        if (e.we) chk("txn_dat", bus.wbm_dat_o, e.dat);
        if (txn_cnt == err_on) begin
            bus.wbm_err_i = 1'b1;
            return;
        end
        bus.wbm_ack_i = 1'b1;
        ofs = bus.wbm_adr_o - BASE;
        if (bus.wbm_we_o) begin
            case (ofs)
                32'h00: begin
                    if (bus.wbm_dat_o[0] && !next_prev) run_filter();
                    next_prev = bus.wbm_dat_o[0];
                end
                32'h04: begin
                    if (bus.wbm_dat_o[0] && !dataw_prev) xmem[waddr] = win;
                    dataw_prev = bus.wbm_dat_o[0];
                end
                32'h08: waddr = bus.wbm_dat_o[4:0];
                32'h0C: win   = bus.wbm_dat_o;
                32'h10: raddr = bus.wbm_dat_o[4:0];
                default: ;
            endcase
        end else begin
            case (ofs)
                32'h10: begin
                    poll_cnt++;
                    bus.wbm_dat_i = {31'b0, !never_valid && run_done && (poll_cnt > valid_delay)};
                end
                32'h1C:  bus.wbm_dat_i = ymem[raddr];
                default: bus.wbm_dat_i = 32'hBAD0_BAD0;
            endcase
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            bus.wbm_dat_i = 32'h0;
            cyc_len = 0; stable_cnt = 0;
            dataw_prev = 1'b0; next_prev = 1'b0; run_done = 1'b0; poll_cnt = 0;
        end else if (bus.wbm_cyc_o && bus.wbm_stb_o && !bus.wbm_ack_i && !bus.wbm_err_i) begin
            if (cyc_len == 0) begin
                first_adr  = bus.wbm_adr_o;
                stable_cnt = 0;
            end
            cyc_len++;
            if (bus.wbm_adr_o == first_adr) stable_cnt++;
            if (cyc_len > wait_states) slave_respond();
        end else begin
            bus.wbm_ack_i = 1'b0;
            bus.wbm_err_i = 1'b0;
            cyc_len = 0; stable_cnt = 0;
        end
    end

    task automatic push_txn(input logic we, input logic [31:0] ofs, input logic [31:0] dat);
        txn_t t;
        t.we = we; t.adr = BASE + ofs; t.dat = dat;
        exp_q.push_back(t);
    endtask

    task automatic push_block(input int polls, input bit full, input int limit);
        for (int i = 0; i < N; i++) begin
            push_txn(1'b1, 32'h08, 32'(i));
            push_txn(1'b1, 32'h0C, 32'(i + 1));
            push_txn(1'b1, 32'h04, 32'h1);
            push_txn(1'b1, 32'h04, 32'h0);
        end
        push_txn(1'b1, 32'h00, 32'h1);
        push_txn(1'b1, 32'h00, 32'h0);
        for (int p = 0; p < polls; p++) push_txn(1'b0, 32'h10, 32'h0);
        if (full) begin
            for (int i = 0; i < N; i++) begin
                push_txn(1'b1, 32'h10, 32'(i));
                push_txn(1'b0, 32'h1C, 32'h0);
            end
        end
        while (exp_q.size() > limit) void'(exp_q.pop_back());
    endtask

    task automatic run_block(input string tag, input int exp_txn, input int exp_done,
                             input logic exp_err, input bit poke);
        int done_cnt;
        int cyc;
        done_cnt = 0;
        cyc      = 0;
        txn_cnt  = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        chk({tag, "_err_clr"}, 32'(error), 32'd0);
        while (busy && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (done) done_cnt++;
            if (poke && cyc == 50) begin
                start = 1'b1; in_we = 1'b1; in_addr = 5'd0; in_data = 32'h0BAD;
            end else begin
                start = 1'b0; in_we = 1'b0;
            end
        end
        if (busy) chk({tag, "_timeout"}, 32'(busy), 32'd0);
        repeat (4) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        chk({tag, "_done_pulses"}, 32'(done_cnt), 32'(exp_done));
        chk({tag, "_error"}, 32'(error), 32'(exp_err));
        chk({tag, "_txn_count"}, 32'(txn_cnt), 32'(exp_txn));
        chk({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_cyc_idle"}, 32'(bus.wbm_cyc_o), 32'd0);
        chk({tag, "_stb_idle"}, 32'(bus.wbm_stb_o), 32'd0);
        chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    endtask

    task automatic check_results(input string tag);
        for (int i = 0; i < N; i++) begin
            out_addr = 5'(i);
            #1;
            chk(tag, out_data, iir_ref(i));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        chk("rst_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(bus.wbm_stb_o), 32'd0);
        chk("rst_we", 32'(bus.wbm_we_o), 32'd0);
        chk("rst_adr", bus.wbm_adr_o, 32'h0);
        chk("rst_dat", bus.wbm_dat_o, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            in_we = 1'b1; in_addr = 5'(i); in_data = 32'(i + 1);
        end
        @(negedge clk); in_we = 1'b0;

        push_block(1, 1'b1, ALL);
        run_block("zero_wait", 6 * N + 3, 1, 1'b0, 1'b1);
        check_results("res_zero_wait");

        wait_states = 3; chk_len = 1'b1;
        push_block(1, 1'b1, ALL);
        run_block("wait3", 6 * N + 3, 1, 1'b0, 1'b0);
        check_results("res_wait3");
        wait_states = 0; chk_len = 1'b0;

        valid_delay = 5;
        push_block(6, 1'b1, ALL);
        run_block("poll6", 6 * N + 8, 1, 1'b0, 1'b0);
        check_results("res_poll6");
        valid_delay = 0;

        never_valid = 1'b1;
        push_block(PL, 1'b0, ALL);
        run_block("poll_timeout", 4 * N + 2 + PL, 0, 1'b1, 1'b0);
        never_valid = 1'b0;

        err_on = 3;
        push_block(0, 1'b0, 3);
        run_block("bus_err", 3, 0, 1'b1, 1'b0);
        check_results("res_after_err");
        err_on = 0;

        push_block(1, 1'b1, ALL);
        run_block("after_err", 6 * N + 3, 1, 1'b0, 1'b0);
        check_results("res_after_err_run");

        never_valid = 1'b1;
        push_block(PL, 1'b0, ALL);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 0;
        while (!(bus.wbm_cyc_o && !bus.wbm_we_o && bus.wbm_adr_o == BASE + 32'h10) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("poll_reached", 32'(bus.wbm_adr_o), BASE + 32'h10);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_cyc", 32'(bus.wbm_cyc_o), 32'd0);
        chk("rst_mid_stb", 32'(bus.wbm_stb_o), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        exp_q.delete();
        never_valid = 1'b0;
        rst = 1'b0;
        push_block(1, 1'b1, ALL);
        run_block("after_rst", 6 * N + 3, 1, 1'b0, 1'b0);
        check_results("res_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
